top_level: RTL and testbench
============================

TOP_LEVEL -- requirements
Module: top_level

Interface
REQ-001 The block SHALL expose `clk` (input, 1): the single clock; all state updates on its rising edge.
REQ-002 The block SHALL expose `rst` (input, 1): synchronous, active-high reset.
REQ-003 The block SHALL expose `stackQueue` (input, 1): 1 selects LIFO stack mode, 0 selects FIFO queue mode.
REQ-004 The block SHALL expose `switches` (input, 16): data operand for push.
REQ-005 The block SHALL expose `btns` (input, 5), each bit a command: [0] push, [1] pop, [2] duplicate, [3] clear, [4] reserved (ignored).
REQ-006 The block SHALL expose `toSSEG` (output, 32): the current element (stack top or queue head) for the display path.
REQ-007 The block SHALL expose `empty` (output, 1): high when occupancy is 0.
REQ-008 The block SHALL expose `full` (output, 1): high when occupancy is 32.

Function
REQ-009 Storage SHALL be an internal instance `mem` with array `memory`: 32 entries x 32 bits.
REQ-010 Each command SHALL execute exactly once per 0->1 transition of its button bit, detected against that bit's value on the previous clock; a held button SHALL not repeat.
REQ-011 Push SHALL write {16'b0, switches} as sampled on the detecting edge.
REQ-012 Stack mode: push writes memory[count]; pop decrements count; the top is memory[count-1]; the i-th push since empty lands in memory[i-1].
REQ-013 Queue mode: push writes memory[tail], then tail=(tail+1) mod 32; pop sets head=(head+1) mod 32; the head element is memory[head]; both pointers SHALL wrap 31->0.
REQ-014 Duplicate SHALL push a copy of the current element; it SHALL be ignored when empty or full.
REQ-015 Push when full SHALL be ignored: memory, pointers and count unchanged; pop when empty SHALL be ignored.
REQ-016 Clear SHALL set count, head and tail to 0 and SHALL not alter memory contents.
REQ-017 When several rising edges are detected in one cycle, only the highest-priority command SHALL execute: clear > push > pop > duplicate.
REQ-018 A change of `stackQueue` SHALL perform a clear in that same cycle, taking priority over any button.
REQ-019 `toSSEG` SHALL be registered and SHALL equal the current element one cycle after the updating edge (mem.data_out); it SHALL be 0 when empty.
REQ-020 `empty` and `full` SHALL be derived combinationally from count (0..32, 6 bits).

Reset
REQ-021 While `rst`=1 at a clock edge: count, head, tail and button-history registers SHALL be 0, `toSSEG`=0, `empty`=1, `full`=0, and all commands SHALL be suppressed.
REQ-022 Reset SHALL not be required to clear memory contents; a reset asserted mid-operation SHALL override any command in that cycle.

Configuration
REQ-023 With macro OCCUPANCY_DISPLAY_EN defined, `toSSEG`[31:16] SHALL carry the zero-extended count while [15:0] carries the element's low half; without it, `toSSEG` SHALL be the full 32-bit element (upper 16 bits 0).

Verification
REQ-024 After reset in stack mode, push 0x1234 with a one-cycle btns[0] pulse -> memory[0]=0x00001234, toSSEG=0x00001234, empty=0.
REQ-025 Stack mode, 35 single pushes of random switch values -> memory[0..31] equal the first 32 values, full=1 after the 32nd push, pushes 33-35 ignored, toSSEG equals the 32nd value.
REQ-026 Queue mode, push 0xA, 0xB, then pop -> toSSEG=0x0000000B; 32 pushes followed by 32 pops -> empty=1, and a further push lands at memory[head] after wrap.
REQ-027 Stack mode, hold btns[0] high for 5 cycles -> exactly one push (count=1).
REQ-028 Stack holding 3 entries, raise btns[3] and btns[0] in the same cycle -> clear wins: count=0, empty=1, toSSEG=0.
REQ-029 Stack holding 2 entries, toggle `stackQueue` -> empty=1 the next cycle.

Source files
------------

// File: rtl/top_level.sv
// Stack/queue of 32 x 32-bit words driven by edge-detected buttons.
// Define OCCUPANCY_DISPLAY_EN to show the count in toSSEG[31:16].
module mem_store (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr,
    input  logic        rd_zero,
    output logic [31:0] cur_o,
    output logic [31:0] data_out
);
    logic [31:0] memory [32];

    assign cur_o = memory[raddr];

    always_ff @(posedge clk) begin
        if (we) begin
            memory[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || rd_zero) begin
            data_out <= 32'd0;
        end else begin
            data_out <= memory[raddr];
        end
    end
endmodule

module top_level (
    input  logic        clk,
    input  logic        rst,
    input  logic        stackQueue,
    input  logic [15:0] switches,
    input  logic [4:0]  btns,
    output logic [31:0] toSSEG,
    output logic        empty,
    output logic        full
);
    logic [3:0]  btn_q;
    logic        mode_q;
    logic [5:0]  count_q, count_d;
    logic [4:0]  head_q, head_d;
    logic [4:0]  tail_q, tail_d;
    logic [3:0]  rise;
    logic        mode_chg;
    logic        we;
    logic [4:0]  wr_addr, rd_addr;
    logic [31:0] wdata, cur, data_out;
    logic        unused_btn;

    assign unused_btn = btns[4];
    assign rise       = btns[3:0] & ~btn_q;
    assign mode_chg   = stackQueue ^ mode_q;
    assign empty      = (count_q == 6'd0);
    assign full       = (count_q == 6'd32);
    assign rd_addr    = stackQueue ? count_q[4:0] - 5'd1 : head_q;
    assign wr_addr    = stackQueue ? count_q[4:0] : tail_q;

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        we      = 1'b0;
        wdata   = {16'd0, switches};
        if (rst) begin
            count_d = 6'd0;
            head_d  = 5'd0;
            tail_d  = 5'd0;
        end else if (mode_chg || rise[3]) begin
            count_d = 6'd0;
            head_d  = 5'd0;
            tail_d  = 5'd0;
        end else if (rise[0]) begin
            if (!full) begin
                we      = 1'b1;
                count_d = count_q + 6'd1;
                tail_d  = stackQueue ? tail_q : tail_q + 5'd1;
            end
        end else if (rise[1]) begin
            if (!empty) begin
                count_d = count_q - 6'd1;
                head_d  = stackQueue ? head_q : head_q + 5'd1;
            end
        end else if (rise[2]) begin
            // duplicate reuses the push path with the current element
            if (!empty && !full) begin
                we      = 1'b1;
                wdata   = cur;
                count_d = count_q + 6'd1;
                tail_d  = stackQueue ? tail_q : tail_q + 5'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_q   <= 4'd0;
            mode_q  <= stackQueue;
            count_q <= 6'd0;
            head_q  <= 5'd0;
            tail_q  <= 5'd0;
        end else begin
            btn_q   <= btns[3:0];
            mode_q  <= stackQueue;
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    mem_store mem (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .waddr    (wr_addr),
        .wdata    (wdata),
        .raddr    (rd_addr),
        .rd_zero  (empty),
        .cur_o    (cur),
        .data_out (data_out)
    );

`ifdef OCCUPANCY_DISPLAY_EN
    logic [5:0] disp_cnt_q;

    // count delayed to line up with the registered read data
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_cnt_q <= 6'd0;
        end else begin
            disp_cnt_q <= count_q;
        end
    end

    assign toSSEG = {10'd0, disp_cnt_q, data_out[15:0]};
`else
    assign toSSEG = data_out;
`endif
endmodule

// File: tb/tb_top_level.sv
// Self-checking bench for top_level against a queue-based model.
module tb_top_level;
    logic        clk = 1'b0;
    logic        rst;
    logic        stackQueue;
    logic [15:0] switches;
    logic [4:0]  btns;
    logic [31:0] toSSEG;
    logic        empty;
    logic        full;

    int vectors = 0;
    int errors  = 0;

    logic [31:0] q[$];
    bit          sq;
    logic [31:0] vals [35];
    logic [31:0] x;

    always #5 clk = ~clk;

    top_level dut (
        .clk        (clk),
        .rst        (rst),
        .stackQueue (stackQueue),
        .switches   (switches),
        .btns       (btns),
        .toSSEG     (toSSEG),
        .empty      (empty),
        .full       (full)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_cur();
        if (q.size() == 0) return 32'd0;
        return sq ? q[$] : q[0];
    endfunction

    function automatic logic [31:0] m_disp();
        logic [31:0] e;
        logic [5:0]  n;
        e = m_cur();
        n = 6'(q.size());
`ifdef OCCUPANCY_DISPLAY_EN
        return {10'd0, n, e[15:0]};
`else
        return e;
`endif
    endfunction

    task automatic m_apply(input logic [3:0] mask, input logic [15:0] sw);
        if (mask[3]) q.delete();
        else if (mask[0]) begin
            if (q.size() < 32) q.push_back({16'd0, sw});
        end else if (mask[1]) begin
            if (q.size() > 0) begin
                if (sq) void'(q.pop_back());
                else void'(q.pop_front());
            end
        end else if (mask[2]) begin
            if (q.size() > 0 && q.size() < 32) q.push_back(m_cur());
        end
    endtask

    task automatic press(input logic [4:0] b);
        btns = b;
        cyc();
        btns = 5'd0;
        cyc();
        cyc();
        m_apply(b[3:0], switches);
    endtask

    task automatic chk_out(input string tag);
        chk({tag, ".sseg"}, toSSEG, m_disp());
        chk({tag, ".empty"}, {31'd0, empty}, {31'd0, q.size() == 0});
        chk({tag, ".full"}, {31'd0, full}, {31'd0, q.size() == 32});
    endtask

    initial begin
        rst = 1'b1;
        stackQueue = 1'b1;
        sq = 1'b1;
        btns = 5'd0;
        switches = 16'd0;
        repeat (3) cyc();
        chk("rst.sseg", toSSEG, 32'd0);
        chk("rst.empty", {31'd0, empty}, 32'd1);
        chk("rst.full", {31'd0, full}, 32'd0);
        rst = 1'b0;
        cyc();

        switches = 16'h1234;
        press(5'b00001);
        chk("push1.mem0", dut.mem.memory[0], 32'h0000_1234);
        chk("push1.empty", {31'd0, empty}, 32'd0);
        chk_out("push1");

        press(5'b01000);
        for (int i = 0; i < 35; i++) begin
            switches = 16'($urandom);
            vals[i] = {16'd0, switches};
            press(5'b00001);
            if (i == 31) chk("fill.full", {31'd0, full}, 32'd1);
        end
        for (int i = 0; i < 32; i++)
            chk($sformatf("fill.mem%0d", i), dut.mem.memory[i], vals[i]);
        chk("fill.top", toSSEG & 32'h0000_ffff, vals[31]);
        chk_out("fill");

        press(5'b01000);
        btns = 5'b00001;
        repeat (5) cyc();
        btns = 5'd0;
        cyc();
        cyc();
        m_apply(4'b0001, switches);
        chk_out("hold");
        press(5'b00010);
        chk("hold.pop_empty", {31'd0, empty}, 32'd1);

        for (int i = 0; i < 3; i++) begin
            switches = 16'(i + 7);
            press(5'b00001);
        end
        switches = 16'h5555;
        press(5'b01001);
        chk("clrpush.empty", {31'd0, empty}, 32'd1);
        chk("clrpush.sseg", toSSEG, 32'd0);

        for (int i = 0; i < 2; i++) begin
            switches = 16'(i + 3);
            press(5'b00001);
        end
        stackQueue = 1'b0;
        cyc();
        chk("mode.empty", {31'd0, empty}, 32'd1);
        cyc();
        cyc();
        sq = 1'b0;
        q.delete();
        chk_out("mode");

        switches = 16'h000A;
        press(5'b00001);
        switches = 16'h000B;
        press(5'b00001);
        press(5'b00010);
        chk("q.headB", toSSEG & 32'h0000_ffff, 32'h0000_000B);
        chk_out("qab");
        for (int i = 0; i < 31; i++) begin
            switches = 16'($urandom);
            press(5'b00001);
        end
        chk("q.full", {31'd0, full}, 32'd1);
        for (int i = 0; i < 32; i++) press(5'b00010);
        chk("q.empty", {31'd0, empty}, 32'd1);
        switches = 16'hBEEF;
        press(5'b00001);
        x = 32'h0000_BEEF;
        chk("q.wrap_mem", dut.mem.memory[(1 + 32) % 32], x);
        chk_out("qwrap");

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                stackQueue = ~stackQueue;
                cyc();
                cyc();
                cyc();
                sq = stackQueue;
                q.delete();
            end else begin
                switches = 16'($urandom);
                if ($urandom_range(0, 3) == 0)
                    press(5'($urandom_range(1, 31)));
                else
                    press(5'b00001 << $urandom_range(0, 2));
            end
            chk_out($sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
